// File: rtl/tape_alu.sv
// rtl/tape_alu.sv - serial add/subtract over two LSB-first symbol tapes into a sum tape.
// Build with TAPE_ALU_SUB_EN defined to include the subtract (borrow) datapath.
module tape_alu #(
    parameter int DEPTH  = 8,
    parameter int HEAD_W = 3
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              mode,
    input  logic              wr_valid,
    input  logic              wr_tape,
    input  logic [HEAD_W-1:0] wr_addr,
    input  logic [1:0]        wr_sym,
    input  logic              start,
    input  logic [HEAD_W-1:0] rd_addr,
    output logic [1:0]        rd_sym,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              equal
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_C0, S_C1, S_FINISH} state_t;

    localparam logic [1:0]        SYM_ONE = 2'b01;
    localparam logic [1:0]        SYM_B   = 2'b10;
    localparam logic [HEAD_W-1:0] LAST    = HEAD_W'(DEPTH - 1);

    logic [1:0]        tape0_q [DEPTH];
    logic [1:0]        tape1_q [DEPTH];
    logic [1:0]        sum_q   [DEPTH];
    state_t            state_q, state_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              equal_q, equal_d;
    logic [1:0]        rd_sym_q, rd_sym_d;

    logic              op_we;
    logic              sum_we;
    logic [1:0]        sum_wdata;
    logic [1:0]        sym_a, sym_b;
    logic              dig_a, dig_b, cin, both_b, carry_out, cout;

`ifdef TAPE_ALU_SUB_EN
    logic              mode_q, mode_d;
    logic              borrow_out;
`else
    logic              unused_mode;
    assign unused_mode = mode;
`endif

    // Symbol 11 decodes as blank; a lone blank digit contributes ZERO.
    always_comb begin
        sym_a     = tape0_q[head_q];
        sym_b     = tape1_q[head_q];
        dig_a     = ~sym_a[1] & sym_a[0];
        dig_b     = ~sym_b[1] & sym_b[0];
        both_b    = sym_a[1] & sym_b[1];
        cin       = (state_q == S_C1);
        carry_out = (dig_a & dig_b) | (dig_a & cin) | (dig_b & cin);
`ifdef TAPE_ALU_SUB_EN
        borrow_out = (~dig_a & dig_b) | (~dig_a & cin) | (dig_b & cin);
        cout       = mode_q ? borrow_out : carry_out;
`else
        cout       = carry_out;
`endif
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        equal_d    = equal_q;
        op_we      = 1'b0;
        sum_we     = 1'b0;
        sum_wdata  = SYM_B;
`ifdef TAPE_ALU_SUB_EN
        mode_d     = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                op_we = wr_valid && (wr_addr <= LAST);
                if (start) begin
                    state_d    = S_CLEAR;
                    head_d     = '0;
                    equal_d    = 1'b1;
                    overflow_d = 1'b0;
`ifdef TAPE_ALU_SUB_EN
                    mode_d     = mode;
`endif
                end
            end
            S_CLEAR: begin
                sum_we = 1'b1;
                if (head_q == LAST) begin
                    head_d  = '0;
                    state_d = S_C0;
                end else begin
                    head_d = head_q + HEAD_W'(1);
                end
            end
            S_C0, S_C1: begin
                if (both_b) begin
                    state_d = S_FINISH;
                    head_d  = '0;
                    if (cin) begin
`ifdef TAPE_ALU_SUB_EN
                        if (mode_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            sum_we    = 1'b1;
                            sum_wdata = SYM_ONE;
                        end
`else
                        sum_we    = 1'b1;
                        sum_wdata = SYM_ONE;
`endif
                    end
                end else begin
                    sum_we    = 1'b1;
                    sum_wdata = {1'b0, dig_a ^ dig_b ^ cin};
                    if (dig_a != dig_b) begin
                        equal_d = 1'b0;
                    end
                    if (head_q == LAST) begin
                        overflow_d = cout;
                        head_d     = '0;
                        state_d    = S_FINISH;
                    end else begin
                        head_d  = head_q + HEAD_W'(1);
                        state_d = cout ? S_C1 : S_C0;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d != S_IDLE);
        rd_sym_d = sum_q[rd_addr];
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                tape0_q[i] <= SYM_B;
                tape1_q[i] <= SYM_B;
                sum_q[i]   <= SYM_B;
            end
            state_q    <= S_IDLE;
            head_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            equal_q    <= 1'b0;
            rd_sym_q   <= 2'b00;
`ifdef TAPE_ALU_SUB_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            equal_q    <= equal_d;
            rd_sym_q   <= rd_sym_d;
`ifdef TAPE_ALU_SUB_EN
            mode_q     <= mode_d;
`endif
            if (op_we) begin
                if (wr_tape) begin
                    tape1_q[wr_addr] <= wr_sym;
                end else begin
                    tape0_q[wr_addr] <= wr_sym;
                end
            end
            if (sum_we) begin
                sum_q[head_q] <= sum_wdata;
            end
        end
    end

    assign rd_sym   = rd_sym_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign equal    = equal_q;

endmodule
